// File: rtl/ofm_accumulator_if.sv
// Output-row stream from the OFM accumulator to the OFM buffer (valid/ready).
interface ofm_accumulator_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYSTOLIC_SIZE = 16
);
  localparam int IDX_W = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;

  logic                                  out_valid;
  logic                                  out_ready;
  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   out_row;
  logic [IDX_W-1:0]                      out_row_idx;

  modport master (output out_valid, output out_row, output out_row_idx, input out_ready);
  modport slave  (input out_valid, input out_row, input out_row_idx, output out_ready);
endinterface

// File: rtl/ofm_accumulator.sv
// OFM accumulator: drains the systolic array bottom row, accumulates tiles across
// input-channel passes, and on the last tile streams requantised int8 rows out.
module ofm_accumulator #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYSTOLIC_SIZE = 16,
  parameter int ACC_WIDTH     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  first_tile,
  input  logic                                  last_tile,
  input  logic                                  relu_en,
  input  logic [4:0]                            shift_amt,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH*2-1:0] result_in,
  output logic                                  ofm_write_en,
  output logic                                  busy,
  output logic                                  done,
  ofm_accumulator_if.master                     ofm
);

  localparam int PSUM_W = 2 * DATA_WIDTH;
  localparam int IDX_W  = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(SYSTOLIC_SIZE - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  // Saturation bounds for the signed DATA_WIDTH output, held one bit wider than
  // the accumulator so the rounding bias can never wrap.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]           state_reg;
  logic [IDX_W-1:0]     k_reg;
  logic                 first_reg;
  logic                 last_reg;
  logic                 relu_reg;
  logic [4:0]           shift_reg;
  logic                 done_reg;
  logic [ACC_WIDTH-1:0] acc_reg [SYSTOLIC_SIZE][SYSTOLIC_SIZE];

  logic [ACC_WIDTH-1:0]                psum_ext [SYSTOLIC_SIZE];
  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] out_row_w;

  // ReLU, round-half-up arithmetic shift, then saturate to the int8 range.
  function automatic logic [DATA_WIDTH-1:0] requant(
    input logic [ACC_WIDTH-1:0] x,
    input logic                 relu,
    input logic [4:0]           sh
  );
    logic signed [ACC_WIDTH:0] v;
    logic signed [ACC_WIDTH:0] bias;
    v    = (relu && x[ACC_WIDTH-1]) ? '0 : {x[ACC_WIDTH-1], x};
    bias = '0;
    if (sh != 5'd0) begin
      bias[sh - 5'd1] = 1'b1;
      v = (v + bias) >>> sh;
    end
    if (v > SAT_MAX)      v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return v[DATA_WIDTH-1:0];
  endfunction

  // Per-column sign extension of the psum bus and requant of the current row.
  for (genvar gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_col
    assign psum_ext[gi] = {{(ACC_WIDTH-PSUM_W){result_in[gi*PSUM_W+PSUM_W-1]}},
                           result_in[gi*PSUM_W +: PSUM_W]};
    assign out_row_w[gi*DATA_WIDTH +: DATA_WIDTH] =
      (state_reg == ST_EMIT) ? requant(acc_reg[k_reg][gi], relu_reg, shift_reg) : '0;
  end

  assign ofm_write_en    = (state_reg == ST_CAPTURE);
  assign busy            = (state_reg != ST_IDLE);
  assign done            = done_reg;
  assign ofm.out_valid   = (state_reg == ST_EMIT);
  assign ofm.out_row     = out_row_w;
  assign ofm.out_row_idx = (state_reg == ST_EMIT) ? k_reg : '0;

  // Control FSM: row counter, latched tile configuration and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
      relu_reg  <= 1'b0;
      shift_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            first_reg <= first_tile;
            last_reg  <= last_tile;
            relu_reg  <= relu_en;
            shift_reg <= shift_amt;
            k_reg     <= '0;
            state_reg <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (k_reg == K_LAST) begin
            k_reg <= '0;
            if (last_reg) begin
              state_reg <= ST_EMIT;
            end else begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end
          end else begin
            k_reg <= k_reg + IDX_W'(1);
          end
        end
        ST_EMIT: begin
          if (ofm.out_ready) begin
            if (k_reg == K_LAST) begin
              k_reg     <= '0;
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end else begin
              k_reg <= k_reg + IDX_W'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Accumulator array: overwrite on the first pass, wrap-around add otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
        for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
          acc_reg[r][c] <= '0;
        end
      end
    end else if (state_reg == ST_CAPTURE) begin
      for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
        acc_reg[k_reg][c] <= first_reg ? psum_ext[c] : acc_reg[k_reg][c] + psum_ext[c];
      end
    end
  end

endmodule

// File: tb/tb_ofm_accumulator.sv
// Directed testbench for ofm_accumulator with S=4.
module tb_ofm_accumulator;
  localparam int DW = 8;
  localparam int S  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, first_tile, last_tile, relu_en;
  logic [4:0]       shift_amt;
  logic [S*DW*2-1:0] result_in;
  logic             ofm_write_en, busy, done;

  integer checks = 0;
  integer errors = 0;

  ofm_accumulator_if #(.DATA_WIDTH(DW), .SYSTOLIC_SIZE(S)) ofm ();

  ofm_accumulator #(.DATA_WIDTH(DW), .SYSTOLIC_SIZE(S), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .first_tile(first_tile),
    .last_tile(last_tile), .relu_en(relu_en), .shift_amt(shift_amt),
    .result_in(result_in), .ofm_write_en(ofm_write_en), .busy(busy),
    .done(done), .ofm(ofm.master)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [S*DW*2-1:0] psum4(input int a, input int b, input int c, input int d);
    logic [15:0] ea, eb, ec, ed;
    ea = 16'(a); eb = 16'(b); ec = 16'(c); ed = 16'(d);
    return {ed, ec, eb, ea};
  endfunction

  function automatic logic [S*DW-1:0] row4(input int a, input int b, input int c, input int d);
    logic [7:0] ea, eb, ec, ed;
    ea = 8'(a); eb = 8'(b); ec = 8'(c); ed = 8'(d);
    return {ed, ec, eb, ea};
  endfunction

  // Pulse start with a configuration, then drive S capture rows; returns write-enable cycle count.
  task automatic run_tile(input logic f, input logic l, input logic r, input logic [4:0] sh,
                          input logic [S-1:0][S*DW*2-1:0] rows, output int we_cnt);
    start = 1'b1; first_tile = f; last_tile = l; relu_en = r; shift_amt = sh;
    tick();
    start = 1'b0; first_tile = 1'b0; last_tile = 1'b0; relu_en = 1'b0; shift_amt = '0;
    we_cnt = 0;
    for (int k = 0; k < S; k++) begin
      if (ofm_write_en) we_cnt++;
      result_in = rows[k];
      tick();
    end
    if (ofm_write_en) we_cnt++;
    result_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; first_tile = 1'b0; last_tile = 1'b0; relu_en = 1'b0;
    shift_amt = '0; result_in = '0; ofm.out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({ofm_write_en, busy, done, ofm.out_valid} !== 4'b0 || ofm.out_row !== '0 || ofm.out_row_idx !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%b busy=%b done=%b valid=%b row=%h idx=%0d expected all 0",
               ofm_write_en, busy, done, ofm.out_valid, ofm.out_row, ofm.out_row_idx);
    end
    rst = 1'b0;
    tick();
    $display("reset: outputs checked after reset");
  endtask

  task automatic test_single_tile();
    logic [S-1:0][S*DW*2-1:0] rows;
    int we_cnt;
    for (int k = 0; k < S; k++) rows[k] = psum4(10*k, 10*k+1, 10*k+2, 10*k+3);
    run_tile(1'b1, 1'b1, 1'b0, 5'd0, rows, we_cnt);
    checks++;
    if (we_cnt !== 4) begin
      errors++;
      $display("FAIL single_we_cycles got=%0d expected=4", we_cnt);
    end
    ofm.out_ready = 1'b1;
    for (int k = 0; k < S; k++) begin
      checks++;
      if (ofm.out_valid !== 1'b1 || ofm.out_row_idx !== 2'(k) || ofm.out_row !== row4(10*k, 10*k+1, 10*k+2, 10*k+3)) begin
        errors++;
        $display("FAIL single_row%0d valid=%b idx=%0d row=%h expected idx=%0d row=%h",
                 k, ofm.out_valid, ofm.out_row_idx, ofm.out_row, k, row4(10*k, 10*k+1, 10*k+2, 10*k+3));
      end
      $display("single: row %0d out_row=%h", k, ofm.out_row);
      tick();
    end
    ofm.out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse done=%b expected 0", done);
    end
  endtask

  task automatic test_two_tiles();
    logic [S-1:0][S*DW*2-1:0] rows;
    int we_cnt;
    for (int k = 0; k < S; k++) rows[k] = psum4(10*k, 10*k+1, 10*k+2, 10*k+3);
    run_tile(1'b1, 1'b0, 1'b0, 5'd0, rows, we_cnt);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ofm.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_first_done done=%b busy=%b valid=%b expected 1 0 0", done, busy, ofm.out_valid);
    end
    $display("two_tiles: first tile captured, done=%b", done);
    run_tile(1'b0, 1'b1, 1'b0, 5'd1, rows, we_cnt);
    ofm.out_ready = 1'b1;
    for (int k = 0; k < S; k++) begin
      checks++;
      if (ofm.out_valid !== 1'b1 || ofm.out_row_idx !== 2'(k) || ofm.out_row !== row4(10*k, 10*k+1, 10*k+2, 10*k+3)) begin
        errors++;
        $display("FAIL two_row%0d valid=%b idx=%0d row=%h expected row=%h",
                 k, ofm.out_valid, ofm.out_row_idx, ofm.out_row, row4(10*k, 10*k+1, 10*k+2, 10*k+3));
      end
      $display("two_tiles: row %0d out_row=%h", k, ofm.out_row);
      tick();
    end
    ofm.out_ready = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL two_done done=%b expected 1", done);
    end
    tick();
  endtask

  task automatic test_sat_relu();
    logic [S-1:0][S*DW*2-1:0] rows;
    logic [S*DW-1:0] exp_row;
    int we_cnt;
    for (int k = 0; k < S; k++) rows[k] = psum4(-300, -1, 200, 32767);
    for (int r = 0; r < 2; r++) begin
      run_tile(1'b1, 1'b1, 1'(r), 5'd0, rows, we_cnt);
      exp_row = (r == 0) ? row4(-128, -1, 127, 127) : row4(0, 0, 127, 127);
      ofm.out_ready = 1'b1;
      for (int k = 0; k < S; k++) begin
        checks++;
        if (ofm.out_valid !== 1'b1 || ofm.out_row !== exp_row) begin
          errors++;
          $display("FAIL sat_relu%0d_row%0d valid=%b row=%h expected=%h", r, k, ofm.out_valid, ofm.out_row, exp_row);
        end
        $display("sat_relu: relu=%0d row %0d out_row=%h", r, k, ofm.out_row);
        tick();
      end
      ofm.out_ready = 1'b0;
      tick();
    end
  endtask

  task automatic test_rounding();
    logic [S-1:0][S*DW*2-1:0] rows;
    int we_cnt;
    for (int k = 0; k < S; k++) rows[k] = psum4(5, 6, -6, -7);
    run_tile(1'b1, 1'b1, 1'b0, 5'd2, rows, we_cnt);
    ofm.out_ready = 1'b1;
    for (int k = 0; k < S; k++) begin
      checks++;
      if (ofm.out_valid !== 1'b1 || ofm.out_row !== row4(1, 2, -1, -2)) begin
        errors++;
        $display("FAIL round_row%0d valid=%b row=%h expected=%h", k, ofm.out_valid, ofm.out_row, row4(1, 2, -1, -2));
      end
      $display("rounding: row %0d out_row=%h", k, ofm.out_row);
      tick();
    end
    ofm.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [S-1:0][S*DW*2-1:0] rows;
    logic [6:0] ready_seq;
    int we_cnt;
    int exp_k;
    int transfers;
    for (int k = 0; k < S; k++) rows[k] = psum4(10*k, 10*k+1, 10*k+2, 10*k+3);
    ready_seq = 7'b1110100; // bit i is out_ready in EMIT cycle i: 0,0,1,0,1,1,1
    run_tile(1'b1, 1'b1, 1'b0, 5'd0, rows, we_cnt);
    exp_k = 0;
    transfers = 0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ofm.out_valid !== 1'b1 || ofm.out_row_idx !== 2'(exp_k) ||
          ofm.out_row !== row4(10*exp_k, 10*exp_k+1, 10*exp_k+2, 10*exp_k+3)) begin
        errors++;
        $display("FAIL bp_cycle%0d valid=%b idx=%0d row=%h expected idx=%0d row=%h", i, ofm.out_valid,
                 ofm.out_row_idx, ofm.out_row, exp_k, row4(10*exp_k, 10*exp_k+1, 10*exp_k+2, 10*exp_k+3));
      end
      ofm.out_ready = ready_seq[i];
      start = (i == 1);
      first_tile = 1'b1;
      $display("backpressure: cycle %0d ready=%b idx=%0d out_row=%h", i, ready_seq[i], ofm.out_row_idx, ofm.out_row);
      if (ofm.out_valid && ready_seq[i]) begin
        transfers++;
        exp_k++;
      end
      tick();
    end
    start = 1'b0; first_tile = 1'b0; ofm.out_ready = 1'b0;
    checks++;
    if (transfers !== 4 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_done transfers=%0d done=%b busy=%b expected 4 1 0", transfers, done, busy);
    end
    tick();
    checks++;
    if (ofm_write_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_start_ignored we=%b busy=%b expected 0 0", ofm_write_en, busy);
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [S-1:0][S*DW*2-1:0] rows;
    int we_cnt;
    int done_seen;
    for (int k = 0; k < S; k++) rows[k] = psum4(10*k, 10*k+1, 10*k+2, 10*k+3);
    run_tile(1'b1, 1'b1, 1'b0, 5'd0, rows, we_cnt);
    ofm.out_ready = 1'b1;
    tick();
    ofm.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({ofm_write_en, busy, done, ofm.out_valid} !== 4'b0 || ofm.out_row !== '0 || ofm.out_row_idx !== '0) begin
      errors++;
      $display("FAIL rst_emit_outputs we=%b busy=%b done=%b valid=%b row=%h idx=%0d expected all 0",
               ofm_write_en, busy, done, ofm.out_valid, ofm.out_row, ofm.out_row_idx);
    end
    tick(); tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) done_seen++;
      tick();
    end
    checks++;
    if (done_seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit_no_done done_cycles=%0d busy=%b expected 0 0", done_seen, busy);
    end
    for (int k = 0; k < S; k++) rows[k] = psum4(5, 5, 5, 5);
    run_tile(1'b1, 1'b1, 1'b0, 5'd0, rows, we_cnt);
    ofm.out_ready = 1'b1;
    for (int k = 0; k < S; k++) begin
      checks++;
      if (ofm.out_valid !== 1'b1 || ofm.out_row_idx !== 2'(k) || ofm.out_row !== row4(5, 5, 5, 5)) begin
        errors++;
        $display("FAIL rst_rerun_row%0d valid=%b idx=%0d row=%h expected=%h", k, ofm.out_valid,
                 ofm.out_row_idx, ofm.out_row, row4(5, 5, 5, 5));
      end
      $display("reset_mid_emit: rerun row %0d out_row=%h", k, ofm.out_row);
      tick();
    end
    ofm.out_ready = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rst_rerun_done done=%b expected 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_two_tiles();
    test_sat_relu();
    test_rounding();
    test_back_to_back();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_accumulator.md
Name: ofm_accumulator

Overview:
- Sits directly downstream of the systolic PE array and consumes its bottom-row psum bus.
- During drain it drives the array's ofm_write_en and captures one S-wide row of 16-bit partial sums per cycle, S rows per tile.
- Accumulates tiles across input-channel passes in a local S x S accumulator.
- On the last tile, applies ReLU, rounding right-shift and int8 saturation, and streams S output rows to the OFM buffer over valid/ready.

Parameters:
- DATA_WIDTH, 8, activation/output element width
- SYSTOLIC_SIZE, 16, array dimension S (rows captured per tile, elements per row)
- ACC_WIDTH, 32, accumulator element width (>= 2*DATA_WIDTH)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse: begin drain of one tile; honoured only in IDLE
- first_tile  in  1  sampled at start: overwrite accumulator instead of adding
- last_tile  in  1  sampled at start: run EMIT after CAPTURE
- relu_en  in  1  sampled at start: clamp negatives to 0 before shift
- shift_amt  in  5  sampled at start: arithmetic right-shift amount, 0..31
- result_in  in  SYSTOLIC_SIZE*DATA_WIDTH*2  array bottom-row psums, column c at bits [c*2*DW +: 2*DW], signed
- ofm_write_en  out  1  drives the array's drain/shift enable
- busy  out  1  high whenever state != IDLE
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts row
- out_row  out  SYSTOLIC_SIZE*DATA_WIDTH  int8 row, column c at [c*DW +: DW]
- out_row_idx  out  clog2(S)  index of the row on out_row
- done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (rst=1 at a clock edge), taking priority over everything:
  - state=IDLE; row counter=0; all accumulator entries=0.
  - All outputs 0, including ofm_write_en, busy, out_valid, done and out_row.
  - Reset mid-CAPTURE or mid-EMIT aborts the tile; no done pulse is produced.
- States: IDLE, CAPTURE, EMIT.
- IDLE:
  - start=1 latches first_tile, last_tile, relu_en and shift_amt; clears the row counter k; next state is CAPTURE.
  - start outside IDLE is ignored.
- CAPTURE (exactly S cycles):
  - ofm_write_en=1 for the whole state.
  - Each cycle samples result_in into accumulator row k:
    - each column is sign-extended 16-bit to ACC_WIDTH;
    - acc[k][c] = first ? ext : acc[k][c] + ext;
    - addition wraps modulo 2^ACC_WIDTH.
  - k increments each cycle. The first captured row is k=0. The array controller guarantees result_in is valid on every CAPTURE cycle.
  - After k=S-1: go to EMIT with k=0 if last, otherwise go to IDLE with done=1 the following cycle.
- EMIT:
  - out_valid=1; out_row_idx=k; out_row is a combinational function of acc[k] and the latched config.
  - Row transfer happens on out_valid & out_ready. On transfer k increments; after transfer of row S-1 go to IDLE and pulse done.
  - While out_ready=0, out_row and out_row_idx hold stable.
  - ofm_write_en=0 throughout EMIT.
- Requant per element x (ACC_WIDTH signed):
  - v = (relu && x<0) ? 0 : x
  - if shift>0: v = (v + (1<<(shift-1))) >>> shift (round half up); shift=0 passes v unchanged
  - saturate to [-128, 127] and take the low DATA_WIDTH bits
- Latency:
  - start→first ofm_write_en: 1 cycle.
  - Last capture→first out_valid: 1 cycle.
  - Minimum tile with last_tile=1 and out_ready held high: 1+S+S cycles to done.
- The accumulator is not cleared at tile end. first_tile is the only intra-run clear.

Test Plan:
- S=4, rst held 3 cycles mid-EMIT → all outputs 0 next cycle; state IDLE; a following first_tile run with result_in column values 5 gives out_row elements all 5 (shift=0).
- Single tile, first=last=1, shift=0, relu=0, row k column c = 10*k+c → rows emitted in order k=0..3 with those values; done asserted 1 cycle after row 3 transfer; ofm_write_en high for exactly 4 cycles.
- Two tiles with the same data: first=1,last=0, then first=0,last=1, shift=1 → outputs (2*(10k+c)+1)>>1 = 10k+c; done pulses after both tiles.
- Saturation/ReLU with psum inputs -300, -1, 200, 32767, shift=0 → relu=0: -128, -1, 127, 127; relu=1: 0, 0, 127, 127.
- Rounding with shift=2 on inputs 5, 6, -6, -7 → 1, 2, -1, -2.
- Backpressure: out_ready toggles 0,0,1,0,1,1,1 during EMIT → out_row/idx stable while ready=0; exactly 4 transfers; start pulsed during EMIT is ignored (no extra CAPTURE).
